// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM status types, arbiter FSM states and
// default arbiter tuning values.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, ISERV, DSERV, TURN} arb_state_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    // Counter widths cover the full legal parameter ranges (1..15, 2..255).
    localparam int STARVE_W = 4;
    localparam int WAIT_W   = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/RAM bundle around the memory arbiter. The master side is the
// icache/dcache/RAM environment; the slave side is the arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     iload;
    word_t     dload;
    logic      ihit;
    logic      dhit;

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit
    );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// RAM-wait monitor: counts cycles spent in service and raises a sticky flag
// once a single access has waited TIMEOUT cycles without ACCESS.
module arb_timeout_ctr import cpu_types_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic busy_i,
    input  logic done_i,
    output logic err_o
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    // Counter saturates at the limit so it cannot wrap while the FSM keeps waiting.
    always_comb begin
        wait_d = '0;
        err_d  = err_q;
        if (busy_i) begin
            wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 1'b1;
            if (wait_q == WAIT_LIM && !done_i)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified RAM port between instruction fetch and data access.
// Data has priority; fetch is forced through after STARVE_MAX data grants.
module mem_arbiter import cpu_types_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus,
    output logic         err_timeout
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    word_t               addr_q, addr_d;
    word_t               store_q, store_d;
    logic                wr_q, wr_d;

    logic dreq, in_serv, done;

    assign dreq    = bus.dREN | bus.dWEN;
    assign in_serv = (state_q == ISERV) || (state_q == DSERV);
    assign done    = in_serv && (bus.ramstate == ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
        end
    end

    // RAM lines come only from the latches so they hold steady for the whole access.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        addr_d       = addr_q;
        store_d      = store_q;
        wr_d         = wr_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.iREN)
                    starve_d = '0;
                if (dreq && (!bus.iREN || starve_q < STARVE_LIM)) begin
                    state_d = DSERV;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    wr_d    = bus.dWEN;
                    if (bus.iREN && starve_q != STARVE_LIM)
                        starve_d = starve_q + 1'b1;
                end else if (bus.iREN) begin
                    state_d  = ISERV;
                    addr_d   = bus.iaddr;
                    starve_d = '0;
                end
            end
            ISERV: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                if (bus.ramstate == ACCESS) begin
                    state_d   = TURN;
                    bus.ihit  = bus.iREN;
                    bus.iload = bus.iREN ? bus.ramload : '0;
                end else if (bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end
            end
            DSERV: begin
                bus.ramREN   = !wr_q;
                bus.ramWEN   = wr_q;
                bus.ramaddr  = addr_q;
                bus.ramstore = store_q;
                if (bus.ramstate == ACCESS) begin
                    state_d   = TURN;
                    bus.dhit  = dreq;
                    bus.dload = dreq ? bus.ramload : '0;
                end else if (bus.ramstate == ERROR) begin
                    state_d = IDLE;
                end
            end
            TURN: state_d = IDLE;
        endcase
    end

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .CLK    (CLK),
        .nRST   (nRST),
        .busy_i (in_serv),
        .done_i (done),
        .err_o  (err_timeout)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model with configurable wait and
// error injection, requester tasks, and a hit scoreboard.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    logic err_timeout;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus.slave),
        .err_timeout (err_timeout)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- RAM model ----------------
    int          wait_cfg = 0;
    int          busy_cnt = 0;
    int          err_req  = 0;
    int          err_done = 0;
    word_t       mem [256];
    logic [255:0] mem_vld = '0;

    function automatic word_t ram_peek(input word_t a);
        return mem_vld[a[9:2]] ? mem[a[9:2]] : 32'h8C21_FF04 + a;
    endfunction

    always_comb begin
        if (!(bus.ramREN || bus.ramWEN))  bus.ramstate = FREE;
        else if (err_req != err_done)     bus.ramstate = ERROR;
        else if (busy_cnt < wait_cfg)     bus.ramstate = BUSY;
        else                              bus.ramstate = ACCESS;
    end

    always_comb bus.ramload = ram_peek(bus.ramaddr);

    always @(posedge CLK) begin
        busy_cnt <= (bus.ramstate == BUSY) ? busy_cnt + 1 : 0;
        if (bus.ramstate == ERROR)
            err_done <= err_done + 1;
        if (bus.ramstate == ACCESS && bus.ramWEN) begin
            mem[bus.ramaddr[9:2]]     <= bus.ramstore;
            mem_vld[bus.ramaddr[9:2]] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic wr; word_t addr; word_t data; } dexp_t;
    word_t iexp [$];
    dexp_t dexp [$];
    int    hitlog [$];     // 1 = fetch hit, 2 = data hit
    int    ihit_cyc = -1;
    int    dhit_cyc = -1;

    always @(negedge CLK) begin : mon
        dexp_t e;
        word_t w;
        if (nRST) begin
            if (bus.ihit) begin
                hitlog.push_back(1);
                ihit_cyc = cyc;
                if (iexp.size() == 0) chk("ihit_unexpected", 1, 0);
                else begin
                    w = iexp.pop_front();
                    chk("iload", bus.iload, w);
                end
            end
            if (bus.dhit) begin
                hitlog.push_back(2);
                dhit_cyc = cyc;
                if (dexp.size() == 0) chk("dhit_unexpected", 1, 0);
                else begin
                    e = dexp.pop_front();
                    chk("d_ramaddr", bus.ramaddr, e.addr);
                    if (e.wr) begin
                        chk("d_ramWEN", bus.ramWEN, 1);
                        chk("d_ramstore", bus.ramstore, e.data);
                    end else begin
                        chk("d_ramREN", bus.ramREN, 1);
                        chk("dload", bus.dload, e.data);
                    end
                end
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_hit(input bit is_d, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge CLK);
            got = is_d ? bus.dhit : bus.ihit;
        end
        if (!got) chk(is_d ? "dhit_wait" : "ihit_wait", 0, 1);
        @(posedge CLK); #1;
    endtask

    task automatic ifetch(input word_t a);
        iexp.push_back(ram_peek(a));
        bus.iaddr = a;
        bus.iREN  = 1'b1;
        wait_hit(1'b0, 40);
        bus.iREN  = 1'b0;
    endtask

    task automatic dacc(input bit wr, input word_t a, input word_t d);
        dexp_t e;
        e.wr   = wr;
        e.addr = a;
        e.data = wr ? d : ram_peek(a);
        dexp.push_back(e);
        bus.daddr  = a;
        bus.dstore = d;
        bus.dWEN   = wr;
        bus.dREN   = !wr;
        wait_hit(1'b1, 40);
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, base;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        nRST = 1'b0;
        tick(2);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_hits", {bus.ihit, bus.dhit}, 0);
        chk("rst_err", err_timeout, 0);
        nRST = 1'b1;
        tick(1);

        // single fetch, two BUSY cycles
        wait_cfg = 2;
        c0 = cyc;
        fork
            ifetch(32'h100);
            begin
                @(negedge CLK); chk("f_c0_ramREN", bus.ramREN, 0);
                @(negedge CLK); chk("f_c1_ramREN", bus.ramREN, 1);
                chk("f_c1_ramaddr", bus.ramaddr, 32'h100);
            end
        join
        chk("f_ihit_cyc", ihit_cyc, c0 + 3);
        chk("f_turn_ramREN", bus.ramREN, 0);
        tick(1);

        // contention: data write wins, then fetch, 3 cycles apart
        wait_cfg = 0;
        c0 = cyc;
        base = hitlog.size();
        fork
            dacc(1'b1, 32'h200, 32'hDEADBEEF);
            ifetch(32'h104);
        join
        chk("c_dhit_cyc", dhit_cyc, c0 + 1);
        chk("c_spacing", ihit_cyc - dhit_cyc, 3);
        chk("c_order0", hitlog[base], 2);
        chk("c_order1", hitlog[base + 1], 1);
        tick(1);

        // starvation: four data grants, forced fetch, then data wins again
        base = hitlog.size();
        fork
            begin ifetch(32'h108); tick(1); ifetch(32'h10C); end
            begin
                for (int k = 0; k < 5; k++) begin
                    dacc(1'b0, 32'h300 + 32'(4 * k), '0);
                    tick(1);
                end
            end
        join
        chk("s_count", hitlog.size() - base, 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("s_order%0d", k), hitlog[base + k], (k == 4 || k == 6) ? 1 : 2);
        tick(1);

        // ERROR once, then the same read is re-granted
        err_req = err_req + 1;
        c0 = cyc;
        fork
            dacc(1'b0, 32'h200, '0);
            begin
                @(negedge CLK); @(negedge CLK);
                chk("e_err_dhit", bus.dhit, 0);
                chk("e_err_dload", bus.dload, 0);
            end
        join
        chk("e_retry_cyc", dhit_cyc, c0 + 3);
        tick(1);

        // fetch dropped mid-service still completes with no hit
        wait_cfg = 3;
        c0 = cyc;
        base = hitlog.size();
        bus.iaddr = 32'h110;
        bus.iREN  = 1'b1;
        tick(2);
        bus.iREN  = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 4) begin
                chk("d_access_ramREN", bus.ramREN, 1);
                chk("d_access_ihit", bus.ihit, 0);
                chk("d_access_iload", bus.iload, 0);
            end
            if (k == 5) chk("d_turn_ramREN", bus.ramREN, 0);
            if (k == 6) chk("d_idle_ramREN", bus.ramREN, 0);
        end
        chk("d_no_hits", hitlog.size() - base, 0);
        tick(1);

        // RAM stuck BUSY on a write: timeout flag, then reset mid-write
        wait_cfg = 1000;
        bus.daddr  = 32'h400;
        bus.dstore = 32'h12345678;
        bus.dWEN   = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                chk("t_ramWEN", bus.ramWEN, 1);
                chk("t_ramstore", bus.ramstore, 32'h12345678);
            end
            if (k == 64) chk("t_err_before", err_timeout, 0);
            if (k == 65) chk("t_err_set", err_timeout, 1);
            if (k == 80) chk("t_err_sticky", err_timeout, 1);
        end
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("r_ramWEN", bus.ramWEN, 0);
        chk("r_ramaddr", bus.ramaddr, 0);
        chk("r_ramstore", bus.ramstore, 0);
        chk("r_err", err_timeout, 0);
        bus.dWEN = 1'b0;
        tick(2);
        nRST = 1'b1;
        wait_cfg = 0;
        tick(1);

        ifetch(32'h114);
        tick(3);
        chk("sb_drained", iexp.size() + dexp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
